// File: rtl/ballot_collector.sv
// Voting-round collector: opens a round, latches one yes/no per voter, closes on all-cast or timeout.
// Optional feature macro BALLOT_CHANGE_EN: cast voters may change their vote; round always runs to timeout.
module ballot_collector #(
   parameter int N_VOTERS    = 4,
   parameter int TIMEOUT_CYC = 16,
   parameter int CNT_W       = 5
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start_i,
   input  logic [N_VOTERS-1:0] yes_i,
   input  logic [N_VOTERS-1:0] no_i,
   input  logic                ack_i,
   output logic [N_VOTERS-1:0] ballot_o,
   output logic [N_VOTERS-1:0] cast_o,
   output logic                valid_o,
   output logic                busy_o,
   output logic                timeout_o
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_OPEN   = 2'd1,
      S_CLOSED = 2'd2
   } state_t;

   state_t              state, state_nxt;
   logic [N_VOTERS-1:0] ballot_q, cast_q;
   logic [N_VOTERS-1:0] acc_yes, acc_no, cast_nxt, ballot_nxt;
   logic [CNT_W-1:0]    cnt_q;
   logic                timeout_q;
   logic                timeout_hit, all_cast, close_now;

   // A press counts only when exactly one of yes/no is asserted for that voter.
   always_comb begin
`ifdef BALLOT_CHANGE_EN
      acc_yes = yes_i & ~no_i;
      acc_no  = no_i & ~yes_i;
`else
      acc_yes = yes_i & ~no_i & ~cast_q;
      acc_no  = no_i & ~yes_i & ~cast_q;
`endif
      cast_nxt    = cast_q | acc_yes | acc_no;
      ballot_nxt  = (ballot_q | acc_yes) & ~acc_no;
      all_cast    = &cast_nxt;
      timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`ifdef BALLOT_CHANGE_EN
      close_now   = timeout_hit;
`else
      close_now   = timeout_hit | all_cast;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (start_i)   state_nxt = S_OPEN;
         S_OPEN:   if (close_now) state_nxt = S_CLOSED;
         S_CLOSED: if (ack_i)     state_nxt = S_IDLE;
         default:                 state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      valid_o = (state == S_CLOSED);
      busy_o  = (state == S_OPEN);
   end

   // Round data: cleared on start, updated only while OPEN, held otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ballot_q  <= '0;
         cast_q    <= '0;
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start_i) begin
                  ballot_q  <= '0;
                  cast_q    <= '0;
                  cnt_q     <= '0;
                  timeout_q <= 1'b0;
               end
            end
            S_OPEN: begin
               ballot_q <= ballot_nxt;
               cast_q   <= cast_nxt;
               cnt_q    <= cnt_q + 1'b1;
               if (timeout_hit && !all_cast) timeout_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign ballot_o  = ballot_q;
   assign cast_o    = cast_q;
   assign timeout_o = timeout_q;

endmodule

// File: tb/tb_ballot_collector.sv
// Directed self-checking bench for ballot_collector.
module tb_ballot_collector;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       start_i = 1'b0;
   logic [3:0] yes_i = '0;
   logic [3:0] no_i = '0;
   logic       ack_i = 1'b0;
   logic [3:0] ballot_o, cast_o;
   logic       valid_o, busy_o, timeout_o;

   int errors = 0;
   int checks = 0;

   ballot_collector #(.N_VOTERS(4), .TIMEOUT_CYC(16), .CNT_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .start_i(start_i), .yes_i(yes_i), .no_i(no_i),
      .ack_i(ack_i), .ballot_o(ballot_o), .cast_o(cast_o), .valid_o(valid_o),
      .busy_o(busy_o), .timeout_o(timeout_o)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_in();
      start_i = 1'b0; yes_i = '0; no_i = '0; ack_i = 1'b0;
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      tick(); tick();
      checks++;
      if ({ballot_o, cast_o, valid_o, busy_o, timeout_o} !== 11'b0) begin
         errors++;
         $display("FAIL reset_outputs got=%b want=%b", {ballot_o, cast_o, valid_o, busy_o, timeout_o}, 11'b0);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_all_yes();
      start_i = 1'b1; tick(); clr_in();
      checks++;
      if (busy_o !== 1'b1) begin errors++; $display("FAIL t1_busy got=%b want=1", busy_o); end
      for (int i = 0; i < 4; i++) begin
         yes_i = 4'b0001 << i;
         tick();
      end
      clr_in();
      checks++;
      if ({ballot_o, cast_o, valid_o, busy_o, timeout_o} !== {4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL t1_closed got=%b want=%b", {ballot_o, cast_o, valid_o, busy_o, timeout_o}, 11'b11111111100);
      end
      ack_i = 1'b1; tick(); clr_in();
      checks++;
      if (valid_o !== 1'b0 || ballot_o !== 4'b1111) begin
         errors++;
         $display("FAIL t1_ack valid=%b ballot=%b want valid=0 ballot=1111", valid_o, ballot_o);
      end
   endtask

   task automatic test_mixed_same_cycle();
      start_i = 1'b1; tick(); clr_in();
      checks++;
      if (ballot_o !== 4'b0000 || cast_o !== 4'b0000) begin
         errors++;
         $display("FAIL t2_cleared ballot=%b cast=%b want 0000 0000", ballot_o, cast_o);
      end
      yes_i = 4'b0101; no_i = 4'b1010; tick(); clr_in();
      checks++;
      if (valid_o !== 1'b1 || ballot_o !== 4'b0101 || cast_o !== 4'b1111) begin
         errors++;
         $display("FAIL t2_closed valid=%b ballot=%b cast=%b want 1 0101 1111", valid_o, ballot_o, cast_o);
      end
      ack_i = 1'b1; tick(); clr_in();
      checks++;
      if (valid_o !== 1'b0 || busy_o !== 1'b0 || ballot_o !== 4'b0101) begin
         errors++;
         $display("FAIL t2_ack valid=%b busy=%b ballot=%b want 0 0 0101", valid_o, busy_o, ballot_o);
      end
   endtask

   task automatic test_timeout();
      start_i = 1'b1; tick(); clr_in();
      yes_i = 4'b0001; tick(); clr_in();
      for (int i = 0; i < 14; i++) tick();
      checks++;
      if (valid_o !== 1'b0 || busy_o !== 1'b1) begin
         errors++;
         $display("FAIL t3_before_timeout valid=%b busy=%b want 0 1", valid_o, busy_o);
      end
      tick();
      checks++;
      if ({valid_o, ballot_o, cast_o, timeout_o} !== {1'b1, 4'b0001, 4'b0001, 1'b1}) begin
         errors++;
         $display("FAIL t3_timeout got=%b want=%b", {valid_o, ballot_o, cast_o, timeout_o}, 10'b1000100011);
      end
      ack_i = 1'b1; tick(); clr_in();
      checks++;
      if (timeout_o !== 1'b1 || valid_o !== 1'b0) begin
         errors++;
         $display("FAIL t3_hold_after_ack timeout=%b valid=%b want 1 0", timeout_o, valid_o);
      end
   endtask

   task automatic test_conflict_press();
      start_i = 1'b1; tick(); clr_in();
      checks++;
      if (timeout_o !== 1'b0) begin errors++; $display("FAIL t4_timeout_cleared got=%b want=0", timeout_o); end
      yes_i = 4'b0100; no_i = 4'b0100; tick(); clr_in();
      checks++;
      if (cast_o !== 4'b0000) begin errors++; $display("FAIL t4_conflict_cast got=%b want=0000", cast_o); end
      no_i = 4'b0100; tick(); clr_in();
      checks++;
      if (cast_o !== 4'b0100 || ballot_o !== 4'b0000) begin
         errors++;
         $display("FAIL t4_no_press cast=%b ballot=%b want 0100 0000", cast_o, ballot_o);
      end
      yes_i = 4'b0100; tick(); clr_in();
      checks++;
      if (ballot_o !== 4'b0000) begin errors++; $display("FAIL t4_locked ballot=%b want=0000", ballot_o); end
   endtask

   task automatic test_reset_midround();
      rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
      start_i = 1'b1; tick(); clr_in();
      yes_i = 4'b0011; tick(); clr_in();
      checks++;
      if (cast_o !== 4'b0011) begin errors++; $display("FAIL t5_two_cast got=%b want=0011", cast_o); end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({ballot_o, cast_o, valid_o, busy_o, timeout_o} !== 11'b0) begin
         errors++;
         $display("FAIL t5_async_reset got=%b want=%b", {ballot_o, cast_o, valid_o, busy_o, timeout_o}, 11'b0);
      end
      tick(); rst_n = 1'b1; tick();
      yes_i = 4'b1111; tick(); clr_in();
      checks++;
      if (cast_o !== 4'b0000 || ballot_o !== 4'b0000 || busy_o !== 1'b0) begin
         errors++;
         $display("FAIL t5_idle_press cast=%b ballot=%b busy=%b want 0000 0000 0", cast_o, ballot_o, busy_o);
      end
   endtask

   task automatic test_closed_ignores();
      int wait_cyc;
      start_i = 1'b1; tick(); clr_in();
      yes_i = 4'b1001; no_i = 4'b0110; tick(); clr_in();
      wait_cyc = 0;
      while (valid_o !== 1'b1 && wait_cyc < 40) begin tick(); wait_cyc++; end
      checks++;
      if (valid_o !== 1'b1) begin errors++; $display("FAIL t6_wait_valid got=%b want=1", valid_o); end
      start_i = 1'b1; no_i = 4'b1111; tick(); clr_in();
      checks++;
      if (valid_o !== 1'b1 || busy_o !== 1'b0 || ballot_o !== 4'b1001) begin
         errors++;
         $display("FAIL t6_closed_hold valid=%b busy=%b ballot=%b want 1 0 1001", valid_o, busy_o, ballot_o);
      end
   endtask

   task automatic test_back_to_back();
      ack_i = 1'b1; tick(); clr_in();
      start_i = 1'b1; tick(); clr_in();
      checks++;
      if (busy_o !== 1'b1 || ballot_o !== 4'b0000 || cast_o !== 4'b0000) begin
         errors++;
         $display("FAIL b2b_restart busy=%b ballot=%b cast=%b want 1 0000 0000", busy_o, ballot_o, cast_o);
      end
      yes_i = 4'b0110; no_i = 4'b1001; tick(); clr_in();
      ack_i = 1'b1; tick(); clr_in();
      ack_i = 1'b1; tick(); clr_in();
      checks++;
      if (valid_o !== 1'b0 || busy_o !== 1'b0 || ballot_o !== 4'b0110) begin
         errors++;
         $display("FAIL b2b_idle valid=%b busy=%b ballot=%b want 0 0 0110", valid_o, busy_o, ballot_o);
      end
   endtask

`ifdef BALLOT_CHANGE_EN
   task automatic test_ballot_change();
      int wait_cyc;
      start_i = 1'b1; tick(); clr_in();
      yes_i = 4'b0001; tick(); clr_in();
      no_i = 4'b0001; tick(); clr_in();
      checks++;
      if (ballot_o[0] !== 1'b0 || cast_o !== 4'b0001) begin
         errors++;
         $display("FAIL t6c_change ballot=%b cast=%b want x..0 0001", ballot_o, cast_o);
      end
      yes_i = 4'b1110; tick(); clr_in();
      checks++;
      if (valid_o !== 1'b0 || busy_o !== 1'b1) begin
         errors++;
         $display("FAIL t6c_no_early valid=%b busy=%b want 0 1", valid_o, busy_o);
      end
      wait_cyc = 0;
      while (valid_o !== 1'b1 && wait_cyc < 40) begin tick(); wait_cyc++; end
      checks++;
      if (wait_cyc !== 13 || timeout_o !== 1'b0 || ballot_o !== 4'b1110) begin
         errors++;
         $display("FAIL t6c_full_round cycles=%0d timeout=%b ballot=%b want 13 0 1110", wait_cyc, timeout_o, ballot_o);
      end
      ack_i = 1'b1; tick(); clr_in();
   endtask
`endif

   initial begin
      test_reset();
`ifdef BALLOT_CHANGE_EN
      test_ballot_change();
`else
      test_all_yes();
      test_mixed_same_cycle();
      test_timeout();
      test_conflict_press();
      test_reset_midround();
      test_closed_ignores();
      test_back_to_back();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
